// File: rtl/ram512_bist_pkg.sv
// ram512_bist_pkg: shared widths, FSM states and March C- element tables
package ram512_bist_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int DEPTH = 512;
  typedef enum logic [1:0] {IDLE, MARCH, DRAIN, DONE} state_t;
  typedef logic [2:0] elem_t;
  localparam elem_t LAST_ELEM = 3'd5;
  // bit i describes element Mi; a value bit of 1 means ~BG
  localparam logic [5:0] EL_DOWN = 6'b011000;
  localparam logic [5:0] EL_RD   = 6'b111110;
  localparam logic [5:0] EL_RVAL = 6'b010100;
  localparam logic [5:0] EL_WR   = 6'b011111;
  localparam logic [5:0] EL_WVAL = 6'b001010;
endpackage

// File: rtl/march_addr_gen.sv
// march_addr_gen: 9-bit up/down address counter with load, enable and terminal flag
module march_addr_gen
  import ram512_bist_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              down,
  input  logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              term
);
  logic dir;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= '0;
      dir <= 1'b0;
    end else if (load) begin
      addr <= down ? ADDR_W'(DEPTH - 1) : '0;
      dir <= down;
    end else if (en) begin
      addr <= dir ? addr - 1'b1 : addr + 1'b1;
    end
  end
  assign term = dir ? addr == '0 : addr == ADDR_W'(DEPTH - 1);
endmodule

// File: rtl/ram512_bist.sv
// ram512_bist: March C- self-test engine driving ram512 and checking both read ports
module ram512_bist
  import ram512_bist_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter logic [DATA_W-1:0] BG = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              fail_port,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] d_in,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] d_out_a,
  input  logic [DATA_W-1:0] d_out_b
);
  state_t state;
  elem_t elem, nxt;
  logic phase, march, accept, rd_cyc, last_op, step, term, ld, ld_down, cmp_v, mis_a, mis_b;
  logic [ADDR_W-1:0] addr, rd_hold, cmp_addr;
  logic [DATA_W-1:0] exp_now, cmp_exp;

  assign march = state == MARCH;
  assign accept = start && (state == IDLE || state == DONE);
  assign nxt = elem + 3'd1;
  // phase 0 is the read half of a read-write element, phase 1 its write half
  assign rd_cyc = march && EL_RD[elem] && !phase;
  assign last_op = !(EL_RD[elem] && EL_WR[elem] && !phase);
  assign step = march && last_op;
  assign ld = accept || (step && term && elem != LAST_ELEM);
  assign ld_down = accept ? 1'b0 : EL_DOWN[nxt];
  assign exp_now = EL_RVAL[elem] ? ~BG : BG;

  march_addr_gen u_addr (
    .clk (clk),
    .reset(reset),
    .load(ld),
    .down(ld_down),
    .en  (step && !term),
    .addr(addr),
    .term(term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      elem <= '0;
      phase <= 1'b0;
      rd_hold <= '0;
    end else begin
      if (rd_cyc) rd_hold <= addr;
      if (accept) begin
        state <= MARCH;
        elem <= '0;
        phase <= 1'b0;
      end else if (march) begin
        phase <= !last_op;
        if (step && term) begin
          if (elem == LAST_ELEM) state <= RD_LAT == 0 ? DONE : DRAIN;
          else elem <= nxt;
        end
      end else if (state == DRAIN) begin
        state <= DONE;
      end
    end
  end

  if (RD_LAT == 0) begin : g_lat0
    assign cmp_v = rd_cyc;
    assign cmp_exp = exp_now;
    assign cmp_addr = addr;
  end else begin : g_lat1
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cmp_v <= 1'b0;
        cmp_exp <= '0;
        cmp_addr <= '0;
      end else begin
        cmp_v <= rd_cyc;
        cmp_exp <= exp_now;
        cmp_addr <= addr;
      end
    end
  end

  assign mis_a = cmp_v && d_out_a != cmp_exp;
  assign mis_b = cmp_v && d_out_b != cmp_exp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || accept) begin
      fail <= 1'b0;
      fail_port <= 1'b0;
      fail_addr <= '0;
      fail_exp <= '0;
      fail_got <= '0;
    end else if (!fail && (mis_a || mis_b)) begin
      fail <= 1'b1;
      fail_port <= !mis_a;
      fail_addr <= cmp_addr;
      fail_exp <= cmp_exp;
      fail_got <= mis_a ? d_out_a : d_out_b;
    end
  end

  assign busy = march || state == DRAIN;
  assign done = state == DONE;
  assign pass = done && !fail;
  assign wr = march && EL_WR[elem] && !rd_cyc;
  assign wr_addr = march ? addr : '0;
  assign d_in = march ? (EL_WVAL[elem] ? ~BG : BG) : '0;
  assign rd_addr_a = rd_cyc ? addr : rd_hold;
  assign rd_addr_b = rd_addr_a;
endmodule

// File: tb/tb_ram512_bist.sv
// tb_ram512_bist: drives ram512_bist against a behavioural RAM with injectable read faults
module tb_ram512_bist;
  localparam logic [15:0] BG2 = 16'hA5A5;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, start2 = 1'b0;
  always #5 clk = ~clk;

  logic busy, done, pass, fail, fail_port, wr;
  logic [8:0] fail_addr, wr_addr, rd_addr_a, rd_addr_b;
  logic [15:0] fail_exp, fail_got, d_in, d_out_a, d_out_b;
  logic busy2, done2, pass2, fail2, fail_port2, wr2;
  logic [8:0] fail_addr2, wr_addr2, rd_addr_a2, rd_addr_b2;
  logic [15:0] fail_exp2, fail_got2, d_in2, d_out_a2, d_out_b2;

  ram512_bist #(.RD_LAT(1), .BG(16'h0000)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail(fail), .fail_port(fail_port), .fail_addr(fail_addr), .fail_exp(fail_exp),
    .fail_got(fail_got), .wr(wr), .wr_addr(wr_addr), .d_in(d_in), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .d_out_a(d_out_a), .d_out_b(d_out_b)
  );
  ram512_bist #(.RD_LAT(1), .BG(BG2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .fail(fail2), .fail_port(fail_port2), .fail_addr(fail_addr2), .fail_exp(fail_exp2),
    .fail_got(fail_got2), .wr(wr2), .wr_addr(wr_addr2), .d_in(d_in2), .rd_addr_a(rd_addr_a2),
    .rd_addr_b(rd_addr_b2), .d_out_a(d_out_a2), .d_out_b(d_out_b2)
  );

  // one-cycle-latency RAMs; the first one can corrupt data returned for one address per port
  logic [15:0] mem [512];
  logic [15:0] mem2 [512];
  logic [15:0] qa, qb, qa2, qb2;
  logic [8:0] ra, rb;
  logic fa_en, fb_en;
  logic [8:0] fa_addr, fb_addr;
  logic [15:0] fa_or, fa_xor, fb_or, fb_xor;
  always @(posedge clk) begin
    if (wr) mem[wr_addr] <= d_in;
    if (wr2) mem2[wr_addr2] <= d_in2;
    qa <= mem[rd_addr_a];
    qb <= mem[rd_addr_b];
    ra <= rd_addr_a;
    rb <= rd_addr_b;
    qa2 <= mem2[rd_addr_a2];
    qb2 <= mem2[rd_addr_b2];
  end
  assign d_out_a = (fa_en && ra == fa_addr) ? (qa | fa_or) ^ fa_xor : qa;
  assign d_out_b = (fb_en && rb == fb_addr) ? (qb | fb_or) ^ fb_xor : qb;
  assign d_out_a2 = qa2;
  assign d_out_b2 = qb2;

  int checks = 0, errors = 0, cyc;
  logic tr_ok;
  logic mf, mp;
  logic [8:0] ma;
  logic [15:0] me, mg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // walks the March C- algorithm over an ideal memory, applying the same read faults
  function automatic void model(input logic [15:0] bg, output logic f, output logic p,
                                output logic [8:0] a, output logic [15:0] e, output logic [15:0] g);
    logic [15:0] m [512];
    bit dn [6] = '{0, 0, 0, 1, 1, 0};
    bit hr [6] = '{0, 1, 1, 1, 1, 1};
    bit rv [6] = '{0, 0, 1, 0, 1, 0};
    bit hw [6] = '{1, 1, 1, 1, 1, 0};
    bit wv [6] = '{0, 1, 0, 1, 0, 0};
    logic [15:0] x, ga, gb;
    int ad;
    f = 0; p = 0; a = 0; e = 0; g = 0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 512; i++) begin
        ad = dn[k] ? 511 - i : i;
        if (hr[k]) begin
          x = rv[k] ? ~bg : bg;
          ga = m[ad];
          gb = m[ad];
          if (fa_en && ad == int'(fa_addr)) ga = (ga | fa_or) ^ fa_xor;
          if (fb_en && ad == int'(fb_addr)) gb = (gb | fb_or) ^ fb_xor;
          if (!f && (ga != x || gb != x)) begin
            f = 1; p = ga == x; a = 9'(ad); e = x; g = ga != x ? ga : gb;
          end
        end
        if (hw[k]) m[ad] = wv[k] ? ~bg : bg;
      end
    end
  endfunction

  task automatic run(input int poke);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    tr_ok = 1'b1;
    while (busy && cyc < 6000) begin
      if (cyc < 512) tr_ok &= wr && wr_addr == 9'(cyc) && d_in == 16'h0000;
      if (cyc == 2560) tr_ok &= !wr && rd_addr_a == 9'h1FF;
      if (cyc == 2562) tr_ok &= !wr && rd_addr_a == 9'h1FE;
      tr_ok &= rd_addr_a == rd_addr_b;
      cyc++;
      start = cyc == poke;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag);
    model(16'h0000, mf, mp, ma, me, mg);
    chk({tag, "_len"}, cyc, 5121);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_pass"}, pass, !mf);
    chk({tag, "_fail"}, fail, mf);
    chk({tag, "_port"}, fail_port, mp);
    chk({tag, "_addr"}, fail_addr, ma);
    chk({tag, "_exp"}, fail_exp, me);
    chk({tag, "_got"}, fail_got, mg);
  endtask

  initial begin
    fa_en = 0; fb_en = 0; fa_addr = 0; fb_addr = 0;
    fa_or = 0; fa_xor = 0; fb_or = 0; fb_xor = 0;
    for (int i = 0; i < 512; i++) begin
      mem[i] = 16'($urandom);
      mem2[i] = 16'($urandom);
    end
    repeat (3) @(negedge clk);
    chk("reset_outs", |{busy, done, pass, fail, fail_port, fail_addr, fail_exp, fail_got,
                        wr, wr_addr, d_in, rd_addr_a, rd_addr_b}, 0);
    chk("reset_outs2", |{busy2, done2, pass2, fail2, fail_port2, fail_addr2, fail_exp2,
                         fail_got2, wr2, wr_addr2, d_in2, rd_addr_a2, rd_addr_b2}, 0);
    reset = 1'b1;

    run(-1);
    chk("trace", tr_ok, 1);
    check_result("clean");

    fa_en = 1; fa_addr = 9'h010; fa_or = 16'h0008;
    run(-1);
    chk("sa1_fail", fail, 1);
    chk("sa1_port", fail_port, 0);
    chk("sa1_addr", fail_addr, 9'h010);
    chk("sa1_exp", fail_exp, 16'h0000);
    chk("sa1_got", fail_got, 16'h0008);
    chk("sa1_pass", pass, 0);
    check_result("sa1");

    fa_en = 0; fa_or = 0;
    fb_en = 1; fb_addr = 9'h1FF; fb_xor = 16'hFFFF;
    run(-1);
    chk("invb_port", fail_port, 1);
    chk("invb_addr", fail_addr, 9'h1FF);
    chk("invb_exp", fail_exp, 16'h0000);
    chk("invb_got", fail_got, 16'hFFFF);
    check_result("invb");

    fb_en = 0; fb_xor = 0;
    run(100);
    check_result("busy_start");

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2000) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_outs", |{busy, done, pass, fail, fail_port, fail_addr, fail_exp, fail_got,
                         wr, wr_addr, d_in, rd_addr_a, rd_addr_b}, 0);
    @(negedge clk); reset = 1'b1;
    run(-1);
    check_result("after_rst");

    repeat (3) begin
      fa_en = 0; fb_en = 0;
      case ($urandom_range(0, 2))
        0: fa_en = 1;
        1: fb_en = 1;
        default: begin fa_en = 1; fb_en = 1; end
      endcase
      fa_addr = 9'($urandom); fb_addr = fa_addr;
      fa_xor = 16'($urandom_range(1, 16'hFFFF)); fb_xor = 16'($urandom_range(1, 16'hFFFF));
      run(-1);
      check_result("rand");
    end

    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    cyc = 0;
    tr_ok = 1'b1;
    while (busy2 && cyc < 6000) begin
      if (cyc < 512) tr_ok &= wr2 && wr_addr2 == 9'(cyc) && d_in2 == BG2;
      cyc++;
      @(negedge clk);
    end
    chk("bg_len", cyc, 5121);
    chk("bg_trace", tr_ok, 1);
    chk("bg_done", done2, 1);
    chk("bg_pass", pass2, 1);
    chk("bg_fail", fail2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram512_bist.md
# ram512_bist

Memory built-in self-test engine for the `ram512` block (512 × 16, two read ports, one write port). On a start pulse it runs a March C- sequence over every address and checks both read ports. It records the first mismatch and reports pass or fail. It sits beside `ram512` and owns its write and read-address ports during test, so a testbench or system controller no longer has to stimulate and check the RAM by hand.

## Interface
- `RD_LAT`, default 1: read latency of `ram512` in cycles from `rd_addr_*` to `d_out_*`. Legal values are 0 and 1 only.
- `BG`, default 16'h0000: background pattern. "0" means `BG` and "1" means `~BG`.

- `clk` input 1: single clock, all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: begin a test. Sampled in IDLE or DONE; ignored otherwise.
- `busy` output 1: test in progress.
- `done` output 1: test complete. Held until the next accepted `start`.
- `pass` output 1: valid while `done`=1; equals 1 iff no mismatch occurred.
- `fail` output 1: sticky, set on the first mismatch.
- `fail_port` output 1: port of the first mismatch (0 = A, 1 = B).
- `fail_addr` output 9: address of the first mismatch.
- `fail_exp` output 16: expected data at the first mismatch.
- `fail_got` output 16: received data at the first mismatch.
- `wr` output 1: write enable to `ram512`.
- `wr_addr` output 9: write address to `ram512`.
- `d_in` output 16: write data to `ram512`.
- `rd_addr_a` output 9: read address to `ram512` port A.
- `rd_addr_b` output 9: read address to `ram512` port B. Always equal to `rd_addr_a`.
- `d_out_a` input 16: read data from `ram512` port A.
- `d_out_b` input 16: read data from `ram512` port B.

## Operation
- **Reset values.** Every output is 0 while `reset`=0.
- **States:**
  - IDLE goes to MARCH on `start`.
  - MARCH goes to DRAIN after the last read of element 5.
  - DRAIN lasts `RD_LAT` cycles (skipped when `RD_LAT`=0), then goes to DONE.
  - DONE goes to MARCH on `start`.
- **Elements, in order:**
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇑(r0)
  - ⇑ runs addresses 0 to 511; ⇓ runs 511 to 0.
- **Per-address cycle schedule:**
  - Write-only element (M0): one W cycle.
  - Read-write elements (M1–M4): an R cycle, then a W cycle at the same address.
  - Read-only element (M5): one R cycle.
  - R cycle: `rd_addr_a` = `rd_addr_b` = addr, `wr`=0.
  - W cycle: `wr`=1, `wr_addr`=addr, `d_in` = element write value.
- **Read address between reads.** `rd_addr_*` holds its last value during W cycles.
- **Data check:**
  - The expected value and the address go through an `RD_LAT`-deep pipeline.
  - Both `d_out_a` and `d_out_b` are compared when the pipeline output is valid.
  - On the first mismatch, `fail`, `fail_port`, `fail_addr`, `fail_exp` and `fail_got` are latched.
  - Port A has priority if both ports mismatch in the same cycle.
  - Later mismatches do not overwrite the latched record.
  - The test always runs to completion.
- **Accepting `start`:** clears `done`, `pass`, `fail` and all `fail_*` fields, and restarts from M0, address 0.
- **`start` while `busy`=1:** no effect.
- **Address counter:** 9-bit up/down. Its terminal count (511 when going up, 0 when going down) advances to the next element with no idle cycle. Up/down direction is loaded at the start of each element.
- **Reset low mid-test:** aborts immediately. All outputs go to 0, and the engine is in IDLE when reset is released.

## Timing
- `busy` rises on the edge that samples `start`. The first cycle of `busy` is M0 writing address 0.
- MARCH lasts exactly 512 + 4×1024 + 512 = 5120 cycles. `busy` stays high for 5120 + `RD_LAT` cycles.
- On the edge that ends `busy`: `done` rises, and `pass` = ~`fail` is valid in the same cycle.
- With `RD_LAT`=1, the compare for an R cycle at cycle t happens at cycle t+1, which is the following W cycle or the next R cycle.
- The `fail_*` fields are valid from the cycle after the mismatching compare.

## Structure
- **Package `ram512_bist_pkg`:**
  - `ADDR_W`=9, `DATA_W`=16, `DEPTH`=512.
  - State enum: IDLE, MARCH, DRAIN, DONE.
  - Element index type (0–5).
  - Per-element constant tables: direction, has_read, read value, has_write, write value.
- **Sub-module `march_addr_gen`:** 9-bit up/down counter with load, enable and a terminal flag.
- **Top level:** FSM, compare pipeline and failure record.

## Test plan
- **Fault-free run.** Healthy `ram512`, `RD_LAT`=1, one-cycle `start` → `busy` high for exactly 5121 cycles, then `done`=1, `pass`=1, `fail`=0.
- **Port A stuck-at-1.** Force bit 3 of `d_out_a` to 1 when `rd_addr_a`=9'h010 → `fail`=1, `fail_port`=0, `fail_addr`=9'h010, `fail_exp`=16'h0000, `fail_got`=16'h0008, `pass`=0 at `done`.
- **Port B corruption.** Invert `d_out_b` at address 9'h1FF → `fail_port`=1, `fail_addr`=9'h1FF, `fail_exp`=16'h0000, `fail_got`=16'hFFFF.
- **`start` while busy.** Pulse `start` at busy-cycle 100 → run length is still 5121 cycles and the result is unchanged.
- **Reset mid-run.** Drive `reset`=0 at busy-cycle 2000 → all outputs are 0 within the same cycle. Release reset and start again → full run and `pass`=1.
- **Trace check.**
  - Cycles 0–511: `wr`=1 with `wr_addr` 0..511 and `d_in` = `BG`.
  - M3 reads begin at address 511 and descend.
  - Repeat the fault-free run with `BG`=16'hA5A5 → `pass`=1.
